// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard producing stall/flush controls for the 5-stage pipeline.
// Optional build macro HZD_PERF_CNT_EN enables the saturating hazard stall-cycle counter.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [AW-1:0]    issue_rd,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic [AW-1:0]    rs_d,
    input  logic [AW-1:0]    rt_d,
    input  logic             rs_use,
    input  logic             rt_use,
    input  logic             early_d,
    input  logic             mdu_ready_e,
    input  logic             except_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic [NREG-1:0]  pending,
    output logic [31:0]      perf_stall_cnt
);

    logic [LAT_W-1:0] cnt [NREG];
    logic             issueWrite;
    logic             exFrozen;
    logic [LAT_W-1:0] issueLatEff;
    logic [LAT_W-1:0] useThresh;
    logic             rsHazard;
    logic             rtHazard;
    logic             hazard;

    // A zero latency is illegal on the issue port and is promoted to the ALU latency.
    function automatic logic [LAT_W-1:0] sanitizeLat(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? LAT_W'(1) : lat;
    endfunction

    assign issueWrite  = issue_valid && issue_wr && (issue_rd != '0);
    assign exFrozen    = !mdu_ready_e;
    assign issueLatEff = sanitizeLat(issue_lat);

    always_ff @(posedge clk) begin
        cnt[0] <= '0;
        for (int r = 1; r < NREG; r++) begin
            if (rst || except_m) begin
                cnt[r] <= '0;
            end else if (issueWrite && (issue_rd == AW'(r))) begin
                cnt[r] <= issueLatEff;
            end else if (!exFrozen && (cnt[r] != '0)) begin
                cnt[r] <= cnt[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (cnt[r] != '0);
        end
    end

    // Normal consumers read in EX a cycle later, so a count of 1 is already forwardable.
    assign useThresh = early_d ? '0 : LAT_W'(1);
    assign rsHazard  = rs_use && (rs_d != '0) && (cnt[rs_d] > useThresh);
    assign rtHazard  = rt_use && (rt_d != '0) && (cnt[rt_d] > useThresh);
    assign hazard    = rsHazard || rtHazard;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (!rst) begin
            stall_f = !except_m && (hazard || exFrozen);
            stall_d = !except_m && (hazard || exFrozen);
            stall_e = exFrozen;
            flush_e = except_m || (hazard && !exFrozen);
            flush_d = except_m;
            flush_m = except_m;
            flush_w = except_m;
        end
    end

`ifdef HZD_PERF_CNT_EN
    logic [31:0] perfCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perfCnt <= '0;
        end else if (hazard && !except_m && (perfCnt != 32'hFFFF_FFFF)) begin
            perfCnt <= perfCnt + 32'd1;
        end
    end

    assign perf_stall_cnt = perfCnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a ready-time reference model.
module tb_hazard_scoreboard;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int LAT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_wr;
    logic [AW-1:0]    issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic [AW-1:0]    rs_d;
    logic [AW-1:0]    rt_d;
    logic             rs_use;
    logic             rt_use;
    logic             early_d;
    logic             mdu_ready_e;
    logic             except_m;
    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             flush_d;
    logic             flush_e;
    logic             flush_m;
    logic             flush_w;
    logic [NREG-1:0]  pending;
    logic [31:0]      perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a result becomes forwardable once enough EX-advancing cycles have elapsed.
    longint advCount;
    longint readyAt [NREG];
    longint perfModel;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .LAT_W(LAT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_wr       (issue_wr),
        .issue_rd       (issue_rd),
        .issue_lat      (issue_lat),
        .rs_d           (rs_d),
        .rt_d           (rt_d),
        .rs_use         (rs_use),
        .rt_use         (rt_use),
        .early_d        (early_d),
        .mdu_ready_e    (mdu_ready_e),
        .except_m       (except_m),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_m        (flush_m),
        .flush_w        (flush_w),
        .pending        (pending),
        .perf_stall_cnt (perf_stall_cnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint remaining(input int r);
        if (r == 0) return 0;
        return (readyAt[r] > advCount) ? readyAt[r] - advCount : 0;
    endfunction

    function automatic bit srcHaz(input bit useIt, input int idx, input bit early);
        longint need;
        need = early ? 0 : 1;
        return useIt && (idx != 0) && (remaining(idx) > need);
    endfunction

    function automatic bit modelHazard();
        return srcHaz(rs_use, int'(rs_d), early_d) || srcHaz(rt_use, int'(rt_d), early_d);
    endfunction

    task automatic idle();
        rst = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0; issue_lat = 3'd1;
        rs_d = '0; rt_d = '0; rs_use = 1'b0; rt_use = 1'b0; early_d = 1'b0;
        mdu_ready_e = 1'b1; except_m = 1'b0;
    endtask

    // Called at a negedge with inputs already driven: check, then advance the model at the posedge.
    task automatic tick();
        bit hz;
        logic [31:0] expPend;
        #2;
        hz = !rst && modelHazard();
        expPend = '0;
        for (int r = 0; r < NREG; r++) expPend[r] = (remaining(r) > 0);
        checkVal("stall_f", {31'd0, stall_f}, {31'd0, !rst && !except_m && (hz || !mdu_ready_e)});
        checkVal("stall_d", {31'd0, stall_d}, {31'd0, !rst && !except_m && (hz || !mdu_ready_e)});
        checkVal("stall_e", {31'd0, stall_e}, {31'd0, !rst && !mdu_ready_e});
        checkVal("flush_e", {31'd0, flush_e}, {31'd0, !rst && (except_m || (hz && mdu_ready_e))});
        checkVal("flush_dmw", {29'd0, flush_d, flush_m, flush_w}, {29'd0, {3{!rst && except_m}}});
        checkVal("pending", pending, expPend);
`ifdef HZD_PERF_CNT_EN
        checkVal("perf_stall_cnt", perf_stall_cnt, perfModel[31:0]);
`else
        checkVal("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        @(posedge clk);
        if (rst) begin
            perfModel = 0;
            for (int r = 0; r < NREG; r++) readyAt[r] = advCount;
        end else begin
            if (hz && !except_m) perfModel++;
            if (except_m) begin
                for (int r = 0; r < NREG; r++) readyAt[r] = advCount;
            end else begin
                if (mdu_ready_e) advCount++;
                if (issue_valid && issue_wr && issue_rd != '0)
                    readyAt[issue_rd] = advCount + ((issue_lat == '0) ? 1 : longint'(issue_lat));
            end
        end
        @(negedge clk);
    endtask

    task automatic issueOp(input int rd, input int lat);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = AW'(rd); issue_lat = LAT_W'(lat);
    endtask

    task automatic doReset();
        idle(); rst = 1'b1;
        tick(); tick();
        idle();
    endtask

    initial begin
        advCount = 0;
        perfModel = 0;
        for (int r = 0; r < NREG; r++) readyAt[r] = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        tick(); tick();
        idle();
        checkVal("reset_pending", pending, 32'd0);
        checkVal("reset_perf", perf_stall_cnt, 32'd0);

        // ALU producer then normal and early consumers
        issueOp(5, 1); tick();
        idle(); rs_use = 1'b1; rs_d = 5'd5; tick();
        idle(); issueOp(5, 1); tick();
        idle(); rs_use = 1'b1; rs_d = 5'd5; early_d = 1'b1; tick(); tick();

        // Load then normal consumer on rt
        idle(); issueOp(8, 2); tick();
        idle(); rt_use = 1'b1; rt_d = 5'd8; tick(); tick(); tick();

        // Long producer with MDU freeze
        idle(); issueOp(3, 5); tick();
        idle(); rs_use = 1'b1; rs_d = 5'd3; mdu_ready_e = 1'b0; tick(); tick(); tick();
        mdu_ready_e = 1'b1; for (int i = 0; i < 6; i++) tick();

        // r0 never tracked; zero latency promoted to 1
        idle(); issueOp(0, 7); tick();
        idle(); rs_use = 1'b1; rs_d = 5'd0; early_d = 1'b1; tick();
        idle(); issueOp(6, 0); tick();
        idle(); rt_use = 1'b1; rt_d = 5'd6; early_d = 1'b1; tick(); tick();

        // Exception kills in-flight producer
        idle(); issueOp(9, 4); tick();
        idle(); rs_use = 1'b1; rs_d = 5'd9; except_m = 1'b1; tick();
        except_m = 1'b0; tick();

        // Reset mid-stall releases
        idle(); issueOp(10, 7); tick();
        idle(); rs_use = 1'b1; rs_d = 5'd10; tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();

        // Load-use then load-to-branch: three hazard cycles in total
        doReset();
        issueOp(8, 2); tick();
        idle(); rt_use = 1'b1; rt_d = 5'd8; tick(); tick();
        idle(); issueOp(9, 2); tick();
        idle(); rs_use = 1'b1; rs_d = 5'd9; early_d = 1'b1; tick(); tick(); tick();
        idle(); #1;
`ifdef HZD_PERF_CNT_EN
        checkVal("perf_sequence", perf_stall_cnt, 32'd3);
`else
        checkVal("perf_sequence", perf_stall_cnt, 32'd0);
`endif
        @(negedge clk);

        // Randomized traffic on a small register window to provoke overlaps
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            issue_valid = ($urandom_range(0, 99) < 60);
            issue_wr    = ($urandom_range(0, 99) < 80);
            issue_rd    = AW'($urandom_range(0, 7));
            issue_lat   = LAT_W'($urandom_range(0, 7));
            rs_d        = AW'($urandom_range(0, 7));
            rt_d        = AW'($urandom_range(0, 7));
            rs_use      = $urandom_range(0, 1) == 1;
            rt_use      = $urandom_range(0, 1) == 1;
            early_d     = ($urandom_range(0, 99) < 25);
            mdu_ready_e = ($urandom_range(0, 99) >= 20);
            except_m    = ($urandom_range(0, 99) < 4);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline hazard/stall controller. A per-register scoreboard of countdown counters tracks in-flight GPR writes and their producer latency (ALU, load, multi-cycle), and generates the stall and flush controls for the 5-stage pipeline from those counters. Comparing stage destination fields alone cannot cover producers with variable latency; the scoreboard can. Sits beside the ID stage: fed by the ID/EX issue point, the EX-stage MDU and the MEM-stage exception logic.

## Interface
- `NREG`, 32: number of architectural registers tracked; register 0 is hardwired zero and never tracked.
- `AW`, 5: register index width, `$clog2(NREG)`.
- `LAT_W`, 3: counter width; maximum producer latency is `2**LAT_W-1`.

- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `issue_valid`  in  1  instruction in ID advances into EX this cycle (already qualified by its own stall/flush upstream)
- `issue_wr`  in  1  issuing instruction writes a GPR
- `issue_rd`  in  AW  destination register of issuing instruction
- `issue_lat`  in  LAT_W  cycles after issue until result is forwardable (ALU=1, load=2, longer for multi-cycle), 1..max
- `rs_d`, `rt_d`  in  AW  source registers of instruction in ID
- `rs_use`, `rt_use`  in  1  source actually read
- `early_d`  in  1  ID instruction consumes its sources in ID (branch compare, jr/jalr)
- `mdu_ready_e`  in  1  MDU in EX done; low freezes EX
- `except_m`  in  1  exception taken in MEM
- `stall_f`, `stall_d`, `stall_e`  out  1  stage hold enables
- `flush_d`, `flush_e`, `flush_m`, `flush_w`  out  1  pipeline register clears
- `pending`  out  NREG  bit r set when counter r nonzero (debug)
- `perf_stall_cnt`  out  32  hazard stall-cycle count (see Configuration)

## Operation
- Per-register counter `cnt[r]`, LAT_W bits; 0 = value obtainable from regfile or forwarding network.
- Update each clock, priority highest first:
  - `rst`: all counters to 0.
  - `except_m`: all counters to 0 (every younger producer is flushed).
  - issue write (`issue_valid & issue_wr & issue_rd!=0`): `cnt[issue_rd] <= issue_lat`. Overrides any nonzero value (WAW). Overrides the same-cycle decrement of that entry.
  - otherwise, if `!stall_e`: every nonzero counter decrements by 1; counters at 0 stay at 0.
  - `stall_e` high: all counters hold. Conservative; may add stall cycles, never loses a hazard.
- Source hazard, per source `s` in {rs, rt}: `use_s & s_d!=0 & cnt[s_d] > (early_d ? 0 : 1)`.
  - Normal consumers need the value one cycle later in EX, so count 1 is forwardable.
  - Early consumers need it now.
- `hazard` = OR of both source hazards.
- `stall_f = stall_d = !except_m & (hazard | !mdu_ready_e)`.
- `stall_e = !mdu_ready_e`.
- `flush_e = except_m | (hazard & mdu_ready_e)`: bubble into EX only when EX actually advances.
- `flush_d = flush_m = flush_w = except_m`.
- The counter lookup for a source matching `issue_rd` in the same cycle uses the pre-update value. The issuing instruction is the older one and is already in `cnt`'s next state; the stall is re-evaluated next cycle.
- `issue_lat` of 0 is illegal; the block treats it as 1.

## Timing
- All stall/flush outputs are combinational from `cnt` and the current inputs: zero-cycle latency.
- `cnt`, `pending` and `perf_stall_cnt` are registered; the new value is visible the cycle after the update.
- Reset: `cnt`=0, `pending`=0, `perf_stall_cnt`=0. While `rst` is high, all stall/flush outputs are forced to 0.
- ALU→dependent ALU: 0 stall cycles. Load→ALU: 1. ALU→branch: 1. Load→branch: 2. Latency-L producer→normal consumer: L-1.
- Reset asserted mid-stall: next cycle all counters are 0 and the stall releases.

## Configuration
- `HZD_PERF_CNT_EN` defined:
  - `perf_stall_cnt` increments by 1 each cycle in which `hazard & !except_m & !rst`.
  - Saturates at `32'hFFFF_FFFF`.
- Not defined: counter logic is removed and `perf_stall_cnt` is tied to 0.

## Test plan
- Issue rd=5 lat=1, next cycle ID reads rs=5 with early_d=0 → no stall. Repeat with early_d=1 → exactly 1 stall cycle, flush_e=1 for that cycle.
- Issue rd=8 lat=2 (load), next cycle rt_d=8 → stall_f=stall_d=1 for 1 cycle, `pending[8]` drops 2 cycles after issue.
- Issue rd=3 lat=5, mdu_ready_e=0 for 3 cycles → `cnt[3]` holds during those cycles; consumer stall lasts 4+3 cycles. During them stall_e=1, flush_e=0.
- Issue rd=0 lat=7, consumer rs=0 → pending=0, no stall.
- Issue rd=9 lat=4, then except_m=1 one cycle later → all flush_* =1, stall_f=0, next cycle `pending`=0 and no stall on r9.
- `HZD_PERF_CNT_EN` build: load-use then load→branch sequence → `perf_stall_cnt`=3. Non-enabled build → 0.
